// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg -- shared TileLink-UL definitions for the RAM responder.
//   * A-channel and D-channel opcode constants
//   * d_resp_t: one complete D-channel response beat
//   * align_mask / lane_mask: address decode helpers
// ---------------------------------------------------------------------------
package tl_pkg;

  // A-channel opcodes
  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITHMETIC  = 3'd2;
  localparam logic [2:0] A_LOGICAL     = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  // D-channel opcodes
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  typedef struct packed {
    logic [2:0]   opcode;
    logic [1:0]   param;
    logic [3:0]   size;
    logic [4:0]   source;
    logic         denied;
    logic [127:0] data;
    logic         corrupt;
  } d_resp_t;

  // Low address bits that must be zero for a 2^size access. Only meaningful
  // for size <= 4; larger sizes are rejected separately.
  function automatic logic [3:0] align_mask(input logic [3:0] size);
    align_mask = 4'((5'd1 << size) - 5'd1);
  endfunction

  // Byte lanes covered by a 2^size access starting at lane 'offset'.
  function automatic logic [15:0] lane_mask(input logic [3:0] size,
                                            input logic [3:0] offset);
    int lo;
    int n;
    lane_mask = '0;
    lo = int'(offset);
    n  = 1 << size;
    for (int b = 0; b < 16; b++) begin
      lane_mask[b] = (b >= lo) && (b < lo + n);
    end
  endfunction

endpackage

// File: rtl/tl_ram_responder_if.sv
// ---------------------------------------------------------------------------
// tl_ram_responder_if -- TileLink-UL A and D channel bundle.
//   A channel (master -> slave): valid, opcode, param, size, source, address,
//                                data, corrupt; ready flows back.
//   D channel (slave -> master): valid, opcode, param, size, source, denied,
//                                data, corrupt; ready flows back.
//   modport master: the requesting agent.
//   modport slave : the responding agent (tl_ram_responder).
// ---------------------------------------------------------------------------
interface tl_ram_responder_if;

  logic         io_a_valid;
  logic         io_a_ready;
  logic [2:0]   io_a_bits_opcode;
  logic [2:0]   io_a_bits_param;
  logic [3:0]   io_a_bits_size;
  logic [4:0]   io_a_bits_source;
  logic [31:0]  io_a_bits_address;
  logic [127:0] io_a_bits_data;
  logic         io_a_bits_corrupt;

  logic         io_d_valid;
  logic         io_d_ready;
  logic [2:0]   io_d_bits_opcode;
  logic [1:0]   io_d_bits_param;
  logic [3:0]   io_d_bits_size;
  logic [4:0]   io_d_bits_source;
  logic         io_d_bits_denied;
  logic [127:0] io_d_bits_data;
  logic         io_d_bits_corrupt;

  modport master (
    output io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
           io_a_bits_source, io_a_bits_address, io_a_bits_data,
           io_a_bits_corrupt, io_d_ready,
    input  io_a_ready, io_d_valid, io_d_bits_opcode, io_d_bits_param,
           io_d_bits_size, io_d_bits_source, io_d_bits_denied,
           io_d_bits_data, io_d_bits_corrupt
  );

  modport slave (
    input  io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
           io_a_bits_source, io_a_bits_address, io_a_bits_data,
           io_a_bits_corrupt, io_d_ready,
    output io_a_ready, io_d_valid, io_d_bits_opcode, io_d_bits_param,
           io_d_bits_size, io_d_bits_source, io_d_bits_denied,
           io_d_bits_data, io_d_bits_corrupt
  );

endinterface

// File: rtl/tl_d_resp_queue.sv
// ---------------------------------------------------------------------------
// tl_d_resp_queue -- 2-entry FIFO of D-channel responses.
//   clock, reset             : clock, synchronous active-high reset
//   enq_valid_i/enq_ready_o  : enqueue handshake, enq_data_i payload
//   deq_valid_o/deq_ready_i  : dequeue handshake, deq_data_o = head entry
// One-bit read/write pointers wrap modulo 2; full_q disambiguates the
// pointers-equal case. enq_ready_o depends only on state.
// ---------------------------------------------------------------------------
module tl_d_resp_queue
  import tl_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    enq_valid_i,
  output logic    enq_ready_o,
  input  d_resp_t enq_data_i,
  output logic    deq_valid_o,
  input  logic    deq_ready_i,
  output d_resp_t deq_data_o
);

  d_resp_t slot_q [2];
  logic    wr_ptr_q, wr_ptr_d;
  logic    rd_ptr_q, rd_ptr_d;
  logic    full_q, full_d;
  logic    empty, enq, deq;

  assign empty       = (wr_ptr_q == rd_ptr_q) && !full_q;
  assign enq_ready_o = !full_q;
  assign deq_valid_o = !empty;
  assign enq         = enq_valid_i && !full_q;
  assign deq         = deq_ready_i && !empty;
  assign deq_data_o  = slot_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    if (enq) wr_ptr_d = !wr_ptr_q;
    if (deq) rd_ptr_d = !rd_ptr_q;
    // Enqueue and dequeue together leave the occupancy unchanged.
    if (enq && !deq)      full_d = (wr_ptr_d == rd_ptr_q);
    else if (deq && !enq) full_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  // NOTE: payload slots are deliberately not reset; the pointers and full
  // flag alone decide whether a slot holds a live response.
  always_ff @(posedge clock) begin
    if (enq) slot_q[wr_ptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/tl_ram_responder.sv
// ---------------------------------------------------------------------------
// tl_ram_responder -- TileLink-UL slave backed by a 16 x 128-bit RAM that
// occupies a 256-byte window at BASE_ADDR.
//   clock, reset : clock, synchronous active-high reset
//   tl (slave)   : A channel in, D channel out
// Pipeline: storage is read/written when an A beat is accepted and the
// response is captured into stage S1; S1 drains into a 2-entry response
// FIFO whose head drives the D channel. Up to three responses in flight.
// ---------------------------------------------------------------------------
module tl_ram_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          ENTRIES   = 16
) (
  input logic               clock,
  input logic               reset,
  tl_ram_responder_if.slave tl
);

  logic [127:0] mem_q [ENTRIES];

  logic         a_ready, a_fire;
  logic         legal, wr_en;
  logic [3:0]   word_idx, lane_off;
  logic [15:0]  wr_mask;
  d_resp_t      resp;

  logic         s1_valid_q, s1_valid_d;
  d_resp_t      s1_resp_q, s1_resp_d;
  logic         s1_advance;

  logic         q_enq_ready, q_deq_valid;
  d_resp_t      head;

  logic         unused_a_param;
  assign unused_a_param = ^tl.io_a_bits_param;

  // -------------------------------------------------------------------------
  // A channel accept and decode
  // -------------------------------------------------------------------------
  // Ready depends only on pipeline state, never on io_d_ready.
  assign a_ready       = !s1_valid_q || q_enq_ready;
  assign tl.io_a_ready = a_ready;
  assign a_fire        = tl.io_a_valid && a_ready;

  assign word_idx = tl.io_a_bits_address[7:4];
  assign lane_off = tl.io_a_bits_address[3:0];
  assign wr_mask  = lane_mask(tl.io_a_bits_size, lane_off);

  assign legal = (tl.io_a_bits_address[31:8] == BASE_ADDR[31:8])
              && (tl.io_a_bits_size <= 4'd4)
              && ((lane_off & align_mask(tl.io_a_bits_size)) == 4'd0);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    resp        = '0;
    resp.size   = tl.io_a_bits_size;
    resp.source = tl.io_a_bits_source;
    wr_en       = 1'b0;
    case (tl.io_a_bits_opcode)
      A_GET: begin
        resp.opcode  = D_ACCESS_ACK_DATA;
        resp.denied  = !legal;
        resp.corrupt = !legal;
        resp.data    = legal ? mem_q[word_idx] : '0;
      end
      A_PUT_FULL, A_PUT_PARTIAL: begin
        resp.opcode = D_ACCESS_ACK;
        resp.denied = !legal;
        wr_en       = legal && !tl.io_a_bits_corrupt;
      end
      A_ARITHMETIC, A_LOGICAL: begin
        resp.opcode  = D_ACCESS_ACK_DATA;
        resp.denied  = 1'b1;
        resp.corrupt = 1'b1;
      end
      A_INTENT: begin
        resp.opcode = D_HINT_ACK;
      end
      default: begin
        resp.opcode = D_ACCESS_ACK;
        resp.denied = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Storage: cleared on reset so any read after reset returns zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else if (a_fire && wr_en) begin
      for (int b = 0; b < 16; b++) begin
        if (wr_mask[b]) mem_q[word_idx][8*b +: 8] <= tl.io_a_bits_data[8*b +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage S1
  // -------------------------------------------------------------------------
  assign s1_advance = s1_valid_q && q_enq_ready;

  always_comb begin
    s1_valid_d = s1_valid_q && !s1_advance;
    s1_resp_d  = s1_resp_q;
    if (a_fire) begin
      s1_valid_d = 1'b1;
      s1_resp_d  = resp;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= s1_valid_d;
    s1_resp_q <= s1_resp_d;
  end

  // -------------------------------------------------------------------------
  // Response FIFO and D channel
  // -------------------------------------------------------------------------
  tl_d_resp_queue u_resp_queue (
    .clock       (clock),
    .reset       (reset),
    .enq_valid_i (s1_valid_q),
    .enq_ready_o (q_enq_ready),
    .enq_data_i  (s1_resp_q),
    .deq_valid_o (q_deq_valid),
    .deq_ready_i (tl.io_d_ready),
    .deq_data_o  (head)
  );

  assign tl.io_d_valid        = q_deq_valid;
  assign tl.io_d_bits_opcode  = head.opcode;
  assign tl.io_d_bits_param   = 2'd0;
  assign tl.io_d_bits_size    = head.size;
  assign tl.io_d_bits_source  = head.source;
  assign tl.io_d_bits_denied  = head.denied;
  assign tl.io_d_bits_data    = head.data;
  assign tl.io_d_bits_corrupt = head.corrupt;

endmodule
